// File: rtl/aurora_pkg.sv
// aurora_pkg: shared Aurora TX datapath types and default constants
package aurora_pkg;

    localparam int AXI_DATA_SIZE = 32;
    localparam int CC_PERIOD_DEF = 10000;
    localparam int CC_LEN_DEF    = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CC
    } tx_buf_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with flush and occupancy count
//   clk, rst          : clock, synchronous active-high reset
//   flush_i           : empties the FIFO at the next edge (overrides push/pop)
//   push_i / din_i    : write request and data (ignored when full)
//   pop_i / dout_o    : read request and head-of-queue data (ignored when empty)
//   full_o, empty_o   : occupancy flags
//   level_o           : entries held, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two >= 4");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic             wr, rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level_o = wptr_q - rptr_q;
    assign full_o  = level_o == (AW + 1)'(DEPTH);
    assign empty_o = wptr_q == rptr_q;
    assign wr      = push_i && !full_o;
    assign rd      = pop_i && !empty_o;
    assign dout_o  = mem_q[rptr_q[AW-1:0]];
    assign wptr_d  = flush_i ? '0 : wptr_q + (AW + 1)'(wr);
    assign rptr_d  = flush_i ? '0 : rptr_q + (AW + 1)'(rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/tx_stream_buffer.sv
// tx_stream_buffer: Aurora TX ingress buffer between user AXI4-Stream and lane data controller
//   clk, rst                     : clock, synchronous active-high reset
//   channel_init_finished        : channel up; low flushes the buffer and returns to IDLE
//   s_axis_tvalid/tready/tlast/tdata : user stream with backpressure
//   axi_valid/axi_last/axi_data  : registered, unbackpressured output beats
//   cc_active                    : clock-compensation window in progress
//   fifo_level                   : buffer occupancy
// Build option: define AURORA_TX_CC_EN to enable periodic clock-compensation
// windows (CC_PERIOD RUN clocks, then CC_LEN CC clocks); otherwise cc_active is 0.
module tx_stream_buffer
    import aurora_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int CC_PERIOD = CC_PERIOD_DEF,
    parameter int CC_LEN    = CC_LEN_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      channel_init_finished,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic [AXI_DATA_SIZE-1:0]  s_axis_tdata,
    output logic                      axi_valid,
    output logic                      axi_last,
    output logic [AXI_DATA_SIZE-1:0]  axi_data,
    output logic                      cc_active,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int FW = AXI_DATA_SIZE + 1;

    if (CC_PERIOD < 1 || CC_LEN < 1) begin : g_bad_cc
        $error("tx_stream_buffer: CC_PERIOD and CC_LEN must be >= 1");
    end

    tx_buf_state_t           state_q, state_d;
    logic                    full, empty, push, pop, cc_block, flush;
    logic [FW-1:0]           head;
    logic                    valid_q, last_q;
    logic [AXI_DATA_SIZE-1:0] data_q;

    assign flush         = !channel_init_finished;
    assign s_axis_tready = !full && state_q != IDLE;
    assign push          = s_axis_tvalid && s_axis_tready;
    // Gating with init keeps axi_valid low on the edge that flushes the buffer.
    assign pop           = !empty && state_q == RUN && !cc_block && channel_init_finished;

`ifdef AURORA_TX_CC_EN
    localparam int CW = $clog2((CC_PERIOD > CC_LEN ? CC_PERIOD : CC_LEN) + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // One counter serves both phases: RUN clocks until a window, then window clocks.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (!channel_init_finished) state_d = IDLE;
        else if (state_q == IDLE) state_d = RUN;
        else if (state_q == RUN) begin
            if (cnt_q == CW'(CC_PERIOD - 1)) state_d = CC;
            else cnt_d = cnt_q + 1'b1;
        end else if (cnt_q == CW'(CC_LEN - 1)) state_d = RUN;
        else cnt_d = cnt_q + 1'b1;
    end

    // Look ahead so no beat is registered into the first window cycle.
    assign cc_block  = state_d == CC;
    assign cc_active = state_q == CC;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`else
    always_comb state_d = channel_init_finished ? RUN : IDLE;

    assign cc_block  = 1'b0;
    assign cc_active = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({s_axis_tlast, s_axis_tdata}),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= pop;
            if (pop) {last_q, data_q} <= head;
        end
    end

    assign axi_valid = valid_q;
    assign axi_last  = last_q;
    assign axi_data  = data_q;

endmodule
